// File: rtl/opcode_fetch_queue.sv
// Instruction-fetch decode stage: a byte FIFO followed by an instruction
// assembler. It decodes the head opcode into cmd/mode/length and presents
// whole instructions over a valid/ready handshake.

package ofq_pkg;

  typedef enum logic [5:0] {
    CMD_NOP, CMD_ADC, CMD_AND, CMD_ASL, CMD_BCC, CMD_BCS, CMD_BEQ, CMD_BIT,
    CMD_BMI, CMD_BNE, CMD_BPL, CMD_BRK, CMD_BVC, CMD_BVS, CMD_CLC, CMD_CLD,
    CMD_CLI, CMD_CLV, CMD_CMP, CMD_CPX, CMD_CPY, CMD_DEC, CMD_DEX, CMD_DEY,
    CMD_EOR, CMD_INC, CMD_INX, CMD_INY, CMD_JMP, CMD_JSR, CMD_LDA, CMD_LDX,
    CMD_LDY, CMD_LSR, CMD_ORA, CMD_PHA, CMD_PHP, CMD_PLA, CMD_PLP, CMD_ROL,
    CMD_ROR, CMD_RTI, CMD_RTS, CMD_SBC, CMD_SEC, CMD_SED, CMD_SEI, CMD_STA,
    CMD_STX, CMD_STY, CMD_TAX, CMD_TAY, CMD_TSX, CMD_TXA, CMD_TXS, CMD_TYA
  } cmd_e;

  typedef enum logic [3:0] {
    MODE_IMPL, MODE_ACC, MODE_IMM, MODE_ZPG, MODE_ZPGX, MODE_ZPGY, MODE_ABS,
    MODE_ABSX, MODE_ABSY, MODE_IND, MODE_XIND, MODE_INDY, MODE_REL
  } mode_e;

endpackage

module opcode_fetch_queue
  import ofq_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int CMD_W  = 6,
  parameter int MODE_W = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     flush,
  input  logic [7:0]               in_byte,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_opcode,
  output logic [CMD_W-1:0]         out_cmd,
  output logic [MODE_W-1:0]        out_mode,
  output logic [15:0]              out_operand,
  output logic [1:0]               out_len,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;

  logic              r_out_valid, r_out_illegal;
  logic [7:0]        r_out_opcode;
  logic [CMD_W-1:0]  r_out_cmd;
  logic [MODE_W-1:0] r_out_mode;
  logic [15:0]       r_out_operand;
  logic [1:0]        r_out_len;

  logic [7:0]  w_op, w_b1, w_b2;
  logic [2:0]  w_aaa, w_bbb;
  cmd_e        w_cmd;
  mode_e       w_mode;
  logic        w_illegal;
  logic [1:0]  w_len;
  logic [15:0] w_operand;
  logic        w_push, w_load;

  // Head opcode and the two following bytes; AW-bit adds wrap modulo DEPTH.
  assign w_op  = r_mem[r_rd_ptr];
  assign w_b1  = r_mem[r_rd_ptr + AW'(1)];
  assign w_b2  = r_mem[r_rd_ptr + AW'(2)];
  assign w_aaa = w_op[7:5];
  assign w_bbb = w_op[4:2];

  // Decode the head opcode using the aaa/bbb/cc field structure of the ISA.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_cmd     = CMD_NOP;
    w_mode    = MODE_IMPL;
    w_illegal = 1'b0;
    case (w_op[1:0])
      2'b01: begin
        case (w_aaa)
          3'd0: w_cmd = CMD_ORA;  3'd1: w_cmd = CMD_AND;
          3'd2: w_cmd = CMD_EOR;  3'd3: w_cmd = CMD_ADC;
          3'd4: w_cmd = CMD_STA;  3'd5: w_cmd = CMD_LDA;
          3'd6: w_cmd = CMD_CMP;  default: w_cmd = CMD_SBC;
        endcase
        case (w_bbb)
          3'd0: w_mode = MODE_XIND;  3'd1: w_mode = MODE_ZPG;
          3'd2: w_mode = MODE_IMM;   3'd3: w_mode = MODE_ABS;
          3'd4: w_mode = MODE_INDY;  3'd5: w_mode = MODE_ZPGX;
          3'd6: w_mode = MODE_ABSY;  default: w_mode = MODE_ABSX;
        endcase
      end
      2'b10: begin
        case (w_aaa)
          3'd0: w_cmd = CMD_ASL;  3'd1: w_cmd = CMD_ROL;
          3'd2: w_cmd = CMD_LSR;  3'd3: w_cmd = CMD_ROR;
          3'd4: w_cmd = CMD_STX;  3'd5: w_cmd = CMD_LDX;
          3'd6: w_cmd = CMD_DEC;  default: w_cmd = CMD_INC;
        endcase
        case (w_bbb)
          3'd0: if (w_aaa == 3'd5) w_mode = MODE_IMM; else w_cmd = CMD_NOP;
          3'd1: w_mode = MODE_ZPG;
          3'd2: begin
            case (w_aaa)
              3'd4:    w_cmd = CMD_TXA;
              3'd5:    w_cmd = CMD_TAX;
              3'd6:    w_cmd = CMD_DEX;
              3'd7:    w_cmd = CMD_NOP;
              default: w_mode = MODE_ACC;
            endcase
          end
          3'd3: w_mode = MODE_ABS;
          3'd5: if (w_aaa == 3'd4 || w_aaa == 3'd5) w_mode = MODE_ZPGY;
                else w_mode = MODE_ZPGX;
          3'd6: if (w_aaa == 3'd4) w_cmd = CMD_TXS;
                else if (w_aaa == 3'd5) w_cmd = CMD_TSX;
                else w_cmd = CMD_NOP;
          3'd7: if (w_aaa == 3'd5) w_mode = MODE_ABSY;
                else if (w_aaa == 3'd4) w_cmd = CMD_NOP;
                else w_mode = MODE_ABSX;
          default: w_cmd = CMD_NOP;
        endcase
      end
      2'b00: begin
        case (w_bbb)
          3'd4: begin
            w_mode = MODE_REL;
            case (w_aaa)
              3'd0: w_cmd = CMD_BPL;  3'd1: w_cmd = CMD_BMI;
              3'd2: w_cmd = CMD_BVC;  3'd3: w_cmd = CMD_BVS;
              3'd4: w_cmd = CMD_BCC;  3'd5: w_cmd = CMD_BCS;
              3'd6: w_cmd = CMD_BNE;  default: w_cmd = CMD_BEQ;
            endcase
          end
          3'd6: begin
            case (w_aaa)
              3'd0: w_cmd = CMD_CLC;  3'd1: w_cmd = CMD_SEC;
              3'd2: w_cmd = CMD_CLI;  3'd3: w_cmd = CMD_SEI;
              3'd4: w_cmd = CMD_TYA;  3'd5: w_cmd = CMD_CLV;
              3'd6: w_cmd = CMD_CLD;  default: w_cmd = CMD_SED;
            endcase
          end
          3'd2: begin
            case (w_aaa)
              3'd0: w_cmd = CMD_PHP;  3'd1: w_cmd = CMD_PLP;
              3'd2: w_cmd = CMD_PHA;  3'd3: w_cmd = CMD_PLA;
              3'd4: w_cmd = CMD_DEY;  3'd5: w_cmd = CMD_TAY;
              3'd6: w_cmd = CMD_INY;  default: w_cmd = CMD_INX;
            endcase
          end
          3'd0: begin
            case (w_aaa)
              3'd0: w_cmd = CMD_BRK;
              3'd1: begin w_cmd = CMD_JSR; w_mode = MODE_ABS; end
              3'd2: w_cmd = CMD_RTI;
              3'd3: w_cmd = CMD_RTS;
              3'd5: begin w_cmd = CMD_LDY; w_mode = MODE_IMM; end
              3'd6: begin w_cmd = CMD_CPY; w_mode = MODE_IMM; end
              3'd7: begin w_cmd = CMD_CPX; w_mode = MODE_IMM; end
              default: w_cmd = CMD_NOP;
            endcase
          end
          default: begin
            case (w_aaa)
              3'd1: w_cmd = CMD_BIT;  3'd2: w_cmd = CMD_JMP;
              3'd3: w_cmd = CMD_JMP;  3'd4: w_cmd = CMD_STY;
              3'd5: w_cmd = CMD_LDY;  3'd6: w_cmd = CMD_CPY;
              3'd7: w_cmd = CMD_CPX;  default: w_cmd = CMD_NOP;
            endcase
            if (w_aaa != 3'd0) begin
              case (w_bbb)
                3'd1: w_mode = MODE_ZPG;
                3'd3: if (w_aaa == 3'd3) w_mode = MODE_IND; else w_mode = MODE_ABS;
                3'd5: w_mode = MODE_ZPGX;
                default: w_mode = MODE_ABSX;
              endcase
            end
          end
        endcase
      end
      default: w_illegal = 1'b1;  // cc == 11: emitted as a 1-byte NOP
    endcase
  end

  // Instruction length from addressing mode, with the JSR/BRK overrides.
  always_comb begin
    case (w_mode)
      MODE_IMPL, MODE_ACC:                     w_len = 2'd1;
      MODE_ABS, MODE_ABSX, MODE_ABSY, MODE_IND: w_len = 2'd3;
      default:                                 w_len = 2'd2;
    endcase
    if (w_op == 8'h20) w_len = 2'd3;
    if (w_op == 8'h00) w_len = 2'd1;
  end

  assign w_operand = (w_len == 2'd3) ? {w_b2, w_b1} :
                     (w_len == 2'd2) ? {8'h00, w_b1} : 16'h0000;

  assign in_ready = (r_count < (AW+1)'(DEPTH)) && !flush;
  assign w_push   = in_valid && in_ready;
  assign w_load   = (!r_out_valid || out_ready) && (r_count >= (AW+1)'(w_len)) && !flush;

  // Byte storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; count and pointers define validity.
    if (w_push) r_mem[r_wr_ptr] <= in_byte;
  end

  // FIFO pointers and occupancy; flush discards everything queued.
  always_ff @(posedge clk or negedge nrst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_load) r_rd_ptr <= r_rd_ptr + AW'(w_len);
      r_count <= r_count + (AW+1)'(w_push) - (w_load ? (AW+1)'(w_len) : '0);
    end
  end

  // Output register: capture a whole instruction or retire the current one.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_out_valid   <= 1'b0;
      r_out_opcode  <= '0;
      r_out_cmd     <= '0;
      r_out_mode    <= '0;
      r_out_operand <= '0;
      r_out_len     <= '0;
      r_out_illegal <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid   <= 1'b1;
      r_out_opcode  <= w_op;
      r_out_cmd     <= CMD_W'(w_cmd);
      r_out_mode    <= MODE_W'(w_mode);
      r_out_operand <= w_operand;
      r_out_len     <= w_len;
      r_out_illegal <= w_illegal;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_opcode  = r_out_opcode;
  assign out_cmd     = r_out_cmd;
  assign out_mode    = r_out_mode;
  assign out_operand = r_out_operand;
  assign out_len     = r_out_len;
  assign out_illegal = r_out_illegal;
  assign count       = r_count;

endmodule

// File: tb/tb_opcode_fetch_queue.sv
// Directed self-checking bench for opcode_fetch_queue.

module tb_opcode_fetch_queue;
  import ofq_pkg::*;

  logic        clk = 1'b0;
  logic        nrst, flush, in_valid, out_ready;
  logic [7:0]  in_byte;
  logic        in_ready, out_valid, out_illegal;
  logic [7:0]  out_opcode;
  logic [5:0]  out_cmd;
  logic [3:0]  out_mode;
  logic [15:0] out_operand;
  logic [1:0]  out_len;
  logic [3:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  opcode_fetch_queue #(.DEPTH(8), .CMD_W(6), .MODE_W(4)) dut (
    .clk(clk), .nrst(nrst), .flush(flush),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_cmd(out_cmd), .out_mode(out_mode),
    .out_operand(out_operand), .out_len(out_len), .out_illegal(out_illegal),
    .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Push one instruction, then check the decoded output one edge later.
  task automatic run_vec(input string tag, input logic [7:0] op, input logic [7:0] b1,
                         input logic [7:0] b2, input int len, input logic [5:0] ecmd,
                         input logic [3:0] emode, input logic [15:0] eopnd);
    push_byte(op);
    if (len > 1) push_byte(b1);
    if (len > 2) push_byte(b2);
    check({tag, "_early"}, out_valid, 0);
    tick();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_cmd"},   out_cmd,   ecmd);
    check({tag, "_mode"},  out_mode,  emode);
    check({tag, "_len"},   out_len,   len);
    check({tag, "_opnd"},  out_operand, eopnd);
    tick();
  endtask

  int idx, n_instr;
  logic acc;

  initial begin
    nrst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b1;
    #12;
    check("rst_count", count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    @(negedge clk); nrst = 1'b1;
    tick();

    // 1-byte instruction latency
    push_byte(8'hEA);
    check("nop_e_valid", out_valid, 0);
    check("nop_e_count", count, 1);
    tick();
    check("nop_valid",  out_valid, 1);
    check("nop_opcode", out_opcode, 8'hEA);
    check("nop_cmd",    out_cmd, CMD_NOP);
    check("nop_len",    out_len, 1);
    check("nop_opnd",   out_operand, 16'h0000);
    check("nop_illeg",  out_illegal, 0);
    tick();
    check("nop_retire", out_valid, 0);

    // 3-byte instruction with an input gap
    push_byte(8'hAD);
    push_byte(8'h34);
    for (int i = 0; i < 3; i++) begin
      check("gap_wait", out_valid, 0);
      tick();
    end
    push_byte(8'h12);
    check("lda_e_valid", out_valid, 0);
    tick();
    check("lda_valid", out_valid, 1);
    check("lda_cmd",   out_cmd, CMD_LDA);
    check("lda_mode",  out_mode, MODE_ABS);
    check("lda_opnd",  out_operand, 16'h1234);
    check("lda_len",   out_len, 3);
    tick();
    run_vec("jsr", 8'h20, 8'h00, 8'h80, 3, CMD_JSR, MODE_ABS, 16'h8000);

    // Assorted modes
    run_vec("lda_indy", 8'hB1, 8'h44, 8'h00, 2, CMD_LDA, MODE_INDY, 16'h0044);
    run_vec("jmp_ind",  8'h6C, 8'hFE, 8'hCA, 3, CMD_JMP, MODE_IND,  16'hCAFE);
    run_vec("asl_a",    8'h0A, 8'h00, 8'h00, 1, CMD_ASL, MODE_ACC,  16'h0000);
    run_vec("beq",      8'hF0, 8'hFC, 8'h00, 2, CMD_BEQ, MODE_REL,  16'h00FC);
    run_vec("ldx_zpy",  8'hB6, 8'h10, 8'h00, 2, CMD_LDX, MODE_ZPGY, 16'h0010);
    run_vec("ldx_absy", 8'hBE, 8'h00, 8'h20, 3, CMD_LDX, MODE_ABSY, 16'h2000);
    run_vec("brk",      8'h00, 8'h00, 8'h00, 1, CMD_BRK, MODE_IMPL, 16'h0000);

    // Backpressure: fill until full
    out_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1;
      in_byte  = (idx % 2 == 1) ? 8'h01 : 8'hA9;
      acc = in_ready;
      tick();
      if (acc) idx++;
      if (!in_ready) break;
    end
    check("bp_pushed", idx, 10);
    check("bp_full_count", count, 8);
    check("bp_full_ready", in_ready, 0);
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_opnd", out_operand, 16'h0001);

    // Release and keep streaming across several pointer wraps
    out_ready = 1'b1;
    n_instr = 0;
    for (int i = 0; i < 120; i++) begin
      in_valid = (idx < 50);
      in_byte  = (idx % 2 == 1) ? 8'h01 : 8'hA9;
      if (out_valid) begin
        n_instr++;
        check("bp_opcode", out_opcode, 8'hA9);
        check("bp_cmd",    out_cmd, CMD_LDA);
        check("bp_mode",   out_mode, MODE_IMM);
        check("bp_opnd",   out_operand, 16'h0001);
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
      if (i == 0) begin
        check("bp_pop_count", count, 6);
        check("bp_reassert", in_ready, 1);
      end
      if (idx >= 50 && count == 0 && !out_valid) break;
    end
    in_valid = 1'b0;
    check("bp_total_bytes", idx, 50);
    check("bp_total_instr", n_instr, 25);
    check("bp_drained", count, 0);

    // Flush with an incomplete JMP queued
    push_byte(8'h4C);
    push_byte(8'h00);
    check("fl_pre_count", count, 2);
    in_valid = 1'b1; in_byte = 8'hFF; flush = 1'b1;
    #1;
    check("fl_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_count", count, 0);
    check("fl_valid", out_valid, 0);
    push_byte(8'hE8);
    tick();
    check("fl_inx_valid", out_valid, 1);
    check("fl_inx_cmd",   out_cmd, CMD_INX);
    check("fl_inx_op",    out_opcode, 8'hE8);
    check("fl_inx_len",   out_len, 1);
    tick();

    // Illegal opcode emitted as 1-byte NOP
    push_byte(8'h03);
    push_byte(8'hEA);
    check("ill_valid",  out_valid, 1);
    check("ill_op",     out_opcode, 8'h03);
    check("ill_flag",   out_illegal, 1);
    check("ill_len",    out_len, 1);
    check("ill_cmd",    out_cmd, CMD_NOP);
    check("ill_mode",   out_mode, MODE_IMPL);
    tick();
    check("ill2_valid", out_valid, 1);
    check("ill2_op",    out_opcode, 8'hEA);
    check("ill2_flag",  out_illegal, 0);
    check("ill2_cmd",   out_cmd, CMD_NOP);
    tick();

    // Reset mid-stream with 5 bytes queued
    out_ready = 1'b0;
    push_byte(8'hEA);
    push_byte(8'hA9);
    push_byte(8'h01);
    push_byte(8'hA9);
    push_byte(8'h01);
    push_byte(8'hA9);
    check("mr_pre_count", count, 5);
    check("mr_pre_valid", out_valid, 1);
    #2;
    nrst = 1'b0;
    #1;
    check("mr_count",   count, 0);
    check("mr_valid",   out_valid, 0);
    check("mr_opcode",  out_opcode, 0);
    check("mr_cmd",     out_cmd, 0);
    check("mr_mode",    out_mode, 0);
    check("mr_opnd",    out_operand, 0);
    check("mr_len",     out_len, 0);
    check("mr_illegal", out_illegal, 0);
    tick();
    nrst = 1'b1;
    out_ready = 1'b1;
    tick();
    check("mr_in_ready", in_ready, 1);
    check("mr_post_count", count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
